// File: rtl/stream_in_vector_ping_pong_if.sv
// Scalar sample stream in, N-element vector stream out, for the ping-pong collector.
interface stream_in_vector_ping_pong_if #(
   parameter int BITS = 8,
   parameter int N    = 3
);
   logic            in_valid;
   logic            in_ready;
   logic            in_first;
   logic [BITS-1:0] a;
   logic            out_valid;
   logic            out_ready;
   logic [BITS-1:0] c [N];
   logic            drop;

   modport master (
      output in_valid, in_first, a, out_ready,
      input  in_ready, out_valid, c, drop
   );

   modport slave (
      input  in_valid, in_first, a, out_ready,
      output in_ready, out_valid, c, drop
   );
endinterface

// File: rtl/stream_in_vector_ping_pong.sv
// Collects N samples into a vector across two banks; vector valid the cycle after its last sample.
// in_ready drops only when both banks hold unread vectors; out_ready never reaches in_ready combinationally.
module stream_in_vector_ping_pong #(
   parameter int BITS = 8,
   parameter int N    = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   stream_in_vector_ping_pong_if.slave   bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [BITS-1:0] bank [2][N];
   logic [1:0]      full;
   logic            wr_bank;
   logic            rd_bank;
   logic [IW-1:0]   wr_idx;
   logic            drop_q;

   logic            accept;
   logic            consume;
   logic            restart;
   logic [IW-1:0]   eidx;

   always_comb begin
      bus.in_ready  = !rst && !full[wr_bank];
      accept        = bus.in_valid && bus.in_ready;
      consume       = full[rd_bank] && bus.out_ready;
      // in_first mid-vector rewinds the filling bank to element 0
      restart       = bus.in_first && (wr_idx != '0);
      eidx          = restart ? '0 : wr_idx;
      bus.out_valid = full[rd_bank];
      bus.drop      = drop_q;
      for (int i = 0; i < N; i++) begin
         bus.c[i] = bank[rd_bank][i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) begin
               bank[b][i] <= '0;
            end
         end
         full    <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_idx  <= '0;
         drop_q  <= 1'b0;
      end else begin
         drop_q <= accept && restart;
         // A consumed bank is always full and a written bank never is, so the two never collide
         if (consume) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
         if (accept) begin
            bank[wr_bank][eidx] <= bus.a;
            if (eidx == IW'(N - 1)) begin
               full[wr_bank] <= 1'b1;
               wr_idx        <= '0;
               wr_bank       <= ~wr_bank;
            end else begin
               wr_idx <= eidx + IW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_stream_in_vector_ping_pong.sv
// Randomised and directed stimulus for the ping-pong collector, checked against a queue model.
module tb_stream_in_vector_ping_pong;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   stream_in_vector_ping_pong_if #(.BITS(8), .N(3)) bus3 ();
   stream_in_vector_ping_pong_if #(.BITS(8), .N(1)) bus1 ();

   stream_in_vector_ping_pong #(.BITS(8), .N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
   stream_in_vector_ping_pong #(.BITS(8), .N(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int n_chk  = 0;
   int n_fail = 0;

   // Model: completed vectors awaiting the consumer, plus the vector being assembled
   logic [23:0] q3 [$];
   logic [23:0] q1 [$];
   logic [23:0] part [2];
   int          cnt [2];
   logic        drop_exp [2];
   int          drops_seen;
   int          hs_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs(input int sel, input logic ordy);
      logic [23:0] obs;
      if (sel == 0) begin
         obs = {bus3.c[2], bus3.c[1], bus3.c[0]};
         check("in_ready_n3", 32'(bus3.in_ready), 32'(q3.size() < 2));
         check("out_valid_n3", 32'(bus3.out_valid), 32'(q3.size() > 0));
         check("drop_n3", 32'(bus3.drop), 32'(drop_exp[0]));
         if (q3.size() > 0) check("vector_n3", 32'(obs), 32'(q3[0]));
         if (bus3.drop === 1'b1) drops_seen++;
         if (bus3.out_valid === 1'b1 && ordy) hs_seen++;
      end else begin
         obs = {16'h0, bus1.c[0]};
         check("in_ready_n1", 32'(bus1.in_ready), 32'(q1.size() < 2));
         check("out_valid_n1", 32'(bus1.out_valid), 32'(q1.size() > 0));
         check("drop_n1", 32'(bus1.drop), 32'(drop_exp[1]));
         if (q1.size() > 0) check("vector_n1", 32'(obs), 32'(q1[0]));
         if (bus1.drop === 1'b1) drops_seen++;
         if (bus1.out_valid === 1'b1 && ordy) hs_seen++;
      end
   endtask

   task automatic step(input int sel, input logic vld, input logic first,
                       input logic [7:0] data, input logic ordy);
      int   pend;
      int   nn;
      logic acc;
      logic nd;
      @(negedge clk);
      check_outputs(sel, ordy);
      bus3.in_valid  = (sel == 0) && vld;
      bus3.in_first  = (sel == 0) && first;
      bus3.a         = data;
      bus3.out_ready = (sel == 0) && ordy;
      bus1.in_valid  = (sel == 1) && vld;
      bus1.in_first  = (sel == 1) && first;
      bus1.a         = data;
      bus1.out_ready = (sel == 1) && ordy;
      pend = (sel == 0) ? q3.size() : q1.size();
      nn   = (sel == 0) ? 3 : 1;
      acc  = vld && (pend < 2);
      nd   = 1'b0;
      if (pend > 0 && ordy) begin
         if (sel == 0) void'(q3.pop_front());
         else          void'(q1.pop_front());
      end
      if (acc) begin
         if (first && cnt[sel] != 0) begin
            nd       = 1'b1;
            cnt[sel] = 0;
            part[sel] = '0;
         end
         part[sel][cnt[sel]*8 +: 8] = data;
         cnt[sel]++;
         if (cnt[sel] == nn) begin
            if (sel == 0) q3.push_back(part[sel]);
            else          q1.push_back(part[sel]);
            cnt[sel]  = 0;
            part[sel] = '0;
         end
      end
      drop_exp[sel] = nd;
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst            = 1'b1;
      bus3.in_valid  = 1'b0;
      bus3.in_first  = 1'b0;
      bus3.a         = '0;
      bus3.out_ready = 1'b0;
      bus1.in_valid  = 1'b0;
      bus1.in_first  = 1'b0;
      bus1.a         = '0;
      bus1.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready_n3", 32'(bus3.in_ready), 32'd0);
      check("rst_out_valid_n3", 32'(bus3.out_valid), 32'd0);
      check("rst_drop_n3", 32'(bus3.drop), 32'd0);
      check("rst_c_n3", 32'({bus3.c[2], bus3.c[1], bus3.c[0]}), 32'd0);
      check("rst_in_ready_n1", 32'(bus1.in_ready), 32'd0);
      check("rst_out_valid_n1", 32'(bus1.out_valid), 32'd0);
      check("rst_c_n1", 32'(bus1.c[0]), 32'd0);
      rst = 1'b0;
      q3.delete();
      q1.delete();
      for (int s = 0; s < 2; s++) begin
         part[s]     = '0;
         cnt[s]      = 0;
         drop_exp[s] = 1'b0;
      end
   endtask

   task automatic drain(input int sel, input int cycles);
      for (int i = 0; i < cycles; i++) step(sel, 1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      do_reset();

      // Back-to-back stream, consumer always ready
      for (int i = 1; i <= 6; i++) step(0, 1'b1, 1'b0, 8'(i), 1'b1);
      drain(0, 3);

      // Consumer stalled: both banks fill, then one vector is released
      for (int i = 1; i <= 9; i++) step(0, 1'b1, 1'b0, 8'(i), 1'b0);
      step(0, 1'b0, 1'b0, 8'h00, 1'b1);
      step(0, 1'b0, 1'b0, 8'h00, 1'b0);
      step(0, 1'b0, 1'b0, 8'h00, 1'b0);
      drain(0, 3);

      // Mid-vector restart discards the partial vector
      drops_seen = 0;
      step(0, 1'b1, 1'b0, 8'd7, 1'b1);
      step(0, 1'b1, 1'b0, 8'd8, 1'b1);
      step(0, 1'b1, 1'b1, 8'd9, 1'b1);
      step(0, 1'b1, 1'b0, 8'd10, 1'b1);
      step(0, 1'b1, 1'b0, 8'd11, 1'b1);
      drain(0, 3);
      check("restart_drop_count", 32'(drops_seen), 32'd1);

      // Reset with a full bank and a partial vector pending
      for (int i = 1; i <= 4; i++) step(0, 1'b1, 1'b0, 8'(i), 1'b0);
      do_reset();
      for (int i = 5; i <= 7; i++) step(0, 1'b1, 1'b0, 8'(i), 1'b1);
      drain(0, 3);

      // Gapped input with random consumer stalls, 20 vectors
      sent    = 0;
      hs_seen = 0;
      for (int cyc = 0; cyc < 3000 && sent < 60; cyc++) begin
         logic vld;
         logic ordy;
         vld  = (cyc % 2) == 0;
         ordy = $urandom_range(0, 3) != 0;
         if (vld && q3.size() < 2) sent++;
         step(0, vld, 1'b0, 8'($urandom), ordy);
      end
      drain(0, 6);
      check("random_vectors_out", 32'(hs_seen), 32'd20);

      // Random restarts mixed in
      for (int cyc = 0; cyc < 80; cyc++) begin
         step(0, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
              8'($urandom), 1'($urandom_range(0, 1)));
      end
      drain(0, 6);

      // Single-element vectors with in_first on every sample
      drops_seen = 0;
      step(1, 1'b1, 1'b1, 8'd5, 1'b1);
      step(1, 1'b1, 1'b1, 8'd6, 1'b1);
      step(1, 1'b1, 1'b1, 8'd7, 1'b1);
      drain(1, 3);
      check("n1_drop_count", 32'(drops_seen), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
